// File: rtl/div8_sched.sv
// rtl/div8_sched.sv - round-robin scheduler around a shared one-bit-per-clock 8-bit restoring divider
// Optional macro DIV8_SCHED_DBZ_FAST_EN: divide-by-zero completes on the accept edge.
module div8_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_q,
  output logic [WIDTH-1:0] rsp_r,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     p_q, p_d;
  logic [WIDTH-1:0]   qacc_q, qacc_d;
  logic               id_q, id_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;

  logic               gnt0, gnt1;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [WIDTH:0]     p_sh, p_nx;
  logic               ge;
  logic [WIDTH-1:0]   q_nx;

  // The pointer only breaks ties; a lone requester always wins.
  assign gnt0  = req0_valid && (!req1_valid || !ptr_q);
  assign gnt1  = req1_valid && (!req0_valid || ptr_q);
  assign sel_a = gnt1 ? req1_a : req0_a;
  assign sel_b = gnt1 ? req1_b : req0_b;

  assign p_sh = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign ge   = (p_sh >= {1'b0, b_q});
  assign p_nx = ge ? (p_sh - {1'b0, b_q}) : p_sh;
  assign q_nx = {qacc_q[WIDTH-2:0], ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      qacc_q  <= '0;
      id_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      qacc_q  <= qacc_d;
      id_q    <= id_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    p_d        = p_q;
    qacc_d     = qacc_q;
    id_d       = id_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Grants are masked while reset is held so no requester sees a phantom accept.
        if (!reset && (gnt0 || gnt1)) begin
          req0_ready = gnt0;
          req1_ready = gnt1;
          id_d       = gnt1;
          ptr_d      = ~gnt1;
          a_d        = sel_a;
          b_d        = sel_b;
          p_d        = '0;
          qacc_d     = '0;
          cnt_d      = CNT_W'(WIDTH - 1);
          state_d    = S_RUN;
`ifdef DIV8_SCHED_DBZ_FAST_EN
          if (sel_b == '0) begin
            quo_d   = '1;
            rem_d   = sel_a;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        a_d    = a_q << 1;
        p_d    = p_nx;
        qacc_d = q_nx;
        if (cnt_q == '0) begin
          quo_d   = q_nx;
          rem_d   = p_nx[WIDTH-1:0];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_id    = id_q;
  assign rsp_q     = quo_q;
  assign rsp_r     = rem_q;

endmodule

// File: doc/div8_sched.md
Name: div8_sched

Overview:
- Sequencing and arbitration controller for the team's 8-bit unsigned restoring divider datapath (shift / trial-subtract / restore).
- Two requesters share one iterative 8-bit division engine, one bit per clock.
- Provides valid/ready request and response handshakes, round-robin grant, and divide-by-zero handling.
- Sits between the two client blocks and the shared shift-subtract datapath.

Parameters:
- WIDTH, 8, operand/quotient/remainder width; only 8 is verified.
- CNT_W, 3, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operand pair
- req0_a  input  8  requester 0 dividend
- req0_b  input  8  requester 0 divisor
- req0_ready  output  1  requester 0 accepted this cycle (grant)
- req1_valid  input  1  requester 1 has an operand pair
- req1_a  input  8  requester 1 dividend
- req1_b  input  8  requester 1 divisor
- req1_ready  output  1  requester 1 accepted this cycle (grant)
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester index of the current result
- rsp_q  output  8  quotient
- rsp_r  output  8  remainder
- busy  output  1  engine not in IDLE

Behaviour:
- Reset (async, any state, including mid-division):
  - state=IDLE, counter=0, RR pointer=0.
  - rsp_valid=0, rsp_id=0, rsp_q=0, rsp_r=0, busy=0, both ready=0.
  - The in-flight operation is discarded and no response is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - reqN_ready is combinational: asserted only in IDLE, for the single granted requester with valid=1.
  - Grant rules: one valid requester is granted; if both are valid, the RR pointer's requester is granted.
  - On an accept edge:
    - Latch A, B and id.
    - Clear the partial remainder P (9 bits) and Q.
    - Set counter=7; go to RUN.
    - RR pointer := ~granted id; the pointer changes only on a grant.
- RUN, one iteration per edge, counter 7 down to 0:
  - P' = {P[7:0], A_sh[7]}, A_sh <<= 1.
  - If P' >= {1'b0,B}: P = P' - B and Q = {Q[6:0],1}; else P = P' and Q = {Q[6:0],0}.
  - The compare and subtract are 9 bits wide, with no overflow possible.
  - After the edge where counter was 0: go to DONE; rsp_q=Q, rsp_r=P[7:0], rsp_valid=1.
- Latency: exactly 8 clock edges from the accept edge to the first cycle rsp_valid=1.
- DONE:
  - rsp_valid, rsp_id, rsp_q and rsp_r are held stable until the edge where rsp_valid && rsp_ready.
  - That edge: rsp_valid=0, go to IDLE.
  - The next accept may occur no earlier than the following edge; there is no same-cycle bypass.
- Requests arriving during RUN/DONE are not accepted and stay pending; requesters must hold valid and operands stable.
- Divide by zero (B=0) follows the normal 8-iteration path. The result falls out naturally: Q=8'hFF, R=A.
- busy=1 in RUN and DONE.
- Any X on reset is illegal; valid inputs are sampled only in IDLE.

Optional Feature:
- Macro: DIV8_SCHED_DBZ_FAST_EN.
- Defined:
  - On accept with B==0, go directly to DONE on the accept edge with rsp_q=8'hFF, rsp_r=A.
  - Latency is 1 edge; rsp_valid is visible in the next cycle.
  - The RR pointer update is unchanged.
- Undefined: B==0 takes the full 8-iteration path; the result is identical and only the latency differs.

Test Plan:
- req0 a=100 b=7, rsp_ready=1 -> rsp_valid exactly 8 edges after accept; q=14, r=2, id=0; busy drops the cycle after the handshake.
- req1 a=255 b=1 -> q=255 r=0 id=1; then a=5 b=9 -> q=0 r=5; then a=200 b=200 -> q=1 r=0.
- Both valid continuously after reset with (req0: 50/3, req1: 77/10):
  - grants go 0,1,0,1;
  - results are 16/2 and 7/7 with the matching rsp_id;
  - a ready is never asserted while busy.
- rsp_ready held 0 for 5 cycles in DONE -> rsp_q/rsp_r/rsp_id stable and no new grant; accept occurs 1 edge after the handshake.
- a=42 b=0 -> q=8'hFF r=42. Latency is 8 without DIV8_SCHED_DBZ_FAST_EN and 1 with it.
- Assert reset at the 4th RUN cycle of 100/7:
  - all outputs go to 0 immediately (async);
  - no response is issued;
  - a subsequent 9/4 returns q=2 r=1 with grant from pointer 0.
